// File: rtl/seg_pkg.sv
// Shared constants for seven-segment display blocks: blank pattern, hex
// segment table and the counter/anode width rules.
package seg_pkg;

    // Active-low segment pattern with every segment (and dp) dark.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Widest display any scanner drives. The top slices AN_OFF_ALL down to
    // its own digit count so "all anodes off" always matches the port width.
    localparam int unsigned MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] AN_OFF_ALL = '1;

    // Active-low {dp,g,f,e,d,c,b,a} for nibbles 0..F, dp bit held at 1.
    // Entry 15 is listed first because packed concatenation is MSB-first.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Counter width for a modulus, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment decode (g..a), full 0-F.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup; the dp bit is left to the caller.
    always_comb begin
        seg_o = HEX_SEG[nibble_i][6:0];
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit common-anode seven-segment scanner: refresh counter,
// anode rotation, blink timing and a per-slot ghosting guard. an and segment
// are registered from the same state so they always switch together.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned BLINK_DIV    = 25000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                segment,
    output logic                      frame_tick
);

    localparam int unsigned REF_W = cnt_w(REFRESH_DIV);
    localparam int unsigned IDX_W = cnt_w(NUM_DIGITS);
    localparam int unsigned BLK_W = cnt_w(BLINK_DIV);

    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_OFF_ALL[NUM_DIGITS-1:0];

    logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  blink_ph_q, blink_ph_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_tick_q, frame_tick_d;

    logic [3:0]            cur_nib;
    logic [6:0]            cur_hex;
    logic                  in_guard;
    logic                  ref_wrap;

    assign cur_nib = digits[int'(idx_q)*4 +: 4];

    seg_hex_decode u_hex (
        .nibble_i (cur_nib),
        .seg_o    (cur_hex)
    );

    // Slot timing and output pattern derived from the current registered state.
    always_comb begin
        ref_wrap     = (ref_cnt_q == REF_LAST);
        in_guard     = (32'(ref_cnt_q) < GUARD_CYCLES);

        ref_cnt_d    = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        idx_d        = idx_q;
        if (ref_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        blink_cnt_d  = (blink_cnt_q == BLK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_ph_d   = (blink_cnt_q == BLK_LAST) ? ~blink_ph_q : blink_ph_q;

        frame_tick_d = ref_wrap && (idx_q == IDX_LAST);

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (!in_guard) begin
            // blank_mask drops the anode too; blink only darkens the segments
            // so the slot keeps its on-time and brightness stays uniform.
            if (!blank_mask[idx_q]) begin
                an_d[idx_q] = 1'b0;
                if (!(blink_mask[idx_q] && blink_ph_q)) begin
                    seg_d = {~dp[idx_q], cur_hex};
                end
            end
        end

        // Disabled: everything returns to its reset value on this edge.
        if (!en) begin
            ref_cnt_d    = '0;
            idx_d        = '0;
            blink_cnt_d  = '0;
            blink_ph_d   = 1'b0;
            frame_tick_d = 1'b0;
            an_d         = AN_OFF;
            seg_d        = SEG_BLANK;
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q    <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            ref_cnt_q    <= ref_cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign segment    = seg_q;
    assign frame_tick = frame_tick_q;

endmodule
